// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one data RAM port between instruction fetch and the memory stage
//
// Purpose:
//   Grants at most one of two requesters per cycle and turns the winner's
//   request into a registered RAM access. The memory stage normally wins
//   contention. A starvation counter forces a fetch grant after STARVE_MAX
//   back-to-back data grants made while fetch was waiting. Every read is
//   tagged with its source so its data returns to the requester that issued it.
//
// Parameters:
//   RAM_LAT     RAM read latency, cycle of o_ram_re to cycle of valid i_ram_rdata (1..4)
//   STARVE_MAX  consecutive data grants tolerated while fetch waits (1..15)
//
// Ports:
//   i_clk, i_rst                   clock; synchronous active-high reset
//   i_if_req, i_if_addr            fetch read request and word address
//   o_if_gnt                       fetch accepted this cycle (combinational)
//   o_if_rvalid, o_if_rdata        fetch read return (one-cycle pulse)
//   i_dm_req, i_dm_we, i_dm_addr   memory-stage request, store flag, word address
//   i_dm_wdata, i_dm_be            store data and byte enables
//   o_dm_gnt                       data request accepted this cycle (combinational)
//   o_dm_rvalid, o_dm_rdata        load return (one-cycle pulse)
//   o_ram_addr/wdata/be/we/re      registered RAM access
//   i_ram_rdata                    RAM read data, valid RAM_LAT cycles after o_ram_re

module ram_port_arbiter #(
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_if_req,
  input  logic [29:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,

  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [29:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_be,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,

  output logic [29:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  output logic [3:0]  o_ram_be,
  output logic        o_ram_we,
  output logic        o_ram_re,
  input  logic [31:0] i_ram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       SRC_IF     = 1'b0;
  localparam logic       SRC_DM     = 1'b1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [3:0] r_starve_cnt;
  logic       w_starved;
  logic       w_if_gnt;
  logic       w_dm_gnt;

  assign w_starved = (r_starve_cnt == STARVE_LIM);

  // Grants depend only on requests, reset and the starve counter, never on
  // i_ram_rdata, so there is no combinational RAM-to-requester path.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (!i_rst) begin
      if (i_dm_req && !(i_if_req && w_starved)) begin
        w_dm_gnt = 1'b1;
      end else if (i_if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  assign o_if_gnt = w_if_gnt;
  assign o_dm_gnt = w_dm_gnt;

  // Counts data grants that bypassed a waiting fetch; any cycle in which fetch
  // is not both waiting and passed over clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_dm_gnt && i_if_req) begin
      if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM access
  // ---------------------------------------------------------------------------
  logic [29:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [3:0]  r_ram_be;
  logic        r_ram_we;
  logic        r_ram_re;
  logic        r_src;

  // Address, data and byte enables hold across idle cycles; only the strobes drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_be    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_src       <= SRC_IF;
    end else if (w_dm_gnt) begin
      r_ram_addr  <= i_dm_addr;
      r_ram_wdata <= i_dm_we ? i_dm_wdata : 32'h0;
      r_ram_be    <= i_dm_we ? i_dm_be : 4'b1111;
      r_ram_we    <= i_dm_we;
      r_ram_re    <= ~i_dm_we;
      r_src       <= SRC_DM;
    end else if (w_if_gnt) begin
      r_ram_addr  <= i_if_addr;
      r_ram_wdata <= 32'h0;
      r_ram_be    <= 4'b1111;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b1;
      r_src       <= SRC_IF;
    end else begin
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_be    = r_ram_be;
  assign o_ram_we    = r_ram_we;
  assign o_ram_re    = r_ram_re;

  // ---------------------------------------------------------------------------
  // Read tag pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 captures the strobe/source currently on the RAM port, so the head
  // stage lines up with the cycle in which the RAM presents that read's data.
  logic [RAM_LAT-1:0] r_tag_vld;
  logic [RAM_LAT-1:0] r_tag_src;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      r_tag_src <= '0;
    end else begin
      r_tag_vld[0] <= r_ram_re;
      r_tag_src[0] <= r_src;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_src[i] <= r_tag_src[i-1];
      end
    end
  end

  logic w_head_vld;
  logic w_if_hit;
  logic w_dm_hit;

  // Returns are suppressed while reset is asserted so no stale read escapes.
  assign w_head_vld = r_tag_vld[RAM_LAT-1] & ~i_rst;
  assign w_if_hit   = w_head_vld & (r_tag_src[RAM_LAT-1] == SRC_IF);
  assign w_dm_hit   = w_head_vld & (r_tag_src[RAM_LAT-1] == SRC_DM);

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // The RAM data is live only in the head cycle, so it is forwarded straight
  // through on the pulse and captured for the requester to see afterwards.
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_if_hit) begin
        r_if_rdata <= i_ram_rdata;
      end
      if (w_dm_hit) begin
        r_dm_rdata <= i_ram_rdata;
      end
    end
  end

  assign o_if_rvalid = w_if_hit;
  assign o_dm_rvalid = w_dm_hit;
  assign o_if_rdata  = w_if_hit ? i_ram_rdata : r_if_rdata;
  assign o_dm_rdata  = w_dm_hit ? i_ram_rdata : r_dm_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
//
// Purpose:
//   Three arbiter instances (RAM read latency 1, 2, 3; STARVE_MAX 3) share one
//   set of directed request inputs. Each drives its own behavioural RAM. A
//   scoreboard model predicts grants, RAM port values and read returns per cycle;
//   directed literal checks pin the model on reset, single fetch, store,
//   contention order, pipelined mixed reads and reset during a read.
//
// Ports: none (top-level bench).

module tb_ram_port_arbiter;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [29:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;

  logic [2:0]  if_gnt_w, if_rvalid_w, dm_gnt_w, dm_rvalid_w, ram_we_w, ram_re_w;
  logic [31:0] if_rdata_w  [3];
  logic [31:0] dm_rdata_w  [3];
  logic [29:0] ram_addr_w  [3];
  logic [31:0] ram_wdata_w [3];
  logic [3:0]  ram_be_w    [3];
  logic [31:0] ram_rdata_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter #(.RAM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt_w[0]),
    .o_if_rvalid(if_rvalid_w[0]), .o_if_rdata(if_rdata_w[0]),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_be(dm_be), .o_dm_gnt(dm_gnt_w[0]), .o_dm_rvalid(dm_rvalid_w[0]),
    .o_dm_rdata(dm_rdata_w[0]), .o_ram_addr(ram_addr_w[0]), .o_ram_wdata(ram_wdata_w[0]),
    .o_ram_be(ram_be_w[0]), .o_ram_we(ram_we_w[0]), .o_ram_re(ram_re_w[0]),
    .i_ram_rdata(ram_rdata_w[0]));

  ram_port_arbiter #(.RAM_LAT(2), .STARVE_MAX(STARVE_MAX)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt_w[1]),
    .o_if_rvalid(if_rvalid_w[1]), .o_if_rdata(if_rdata_w[1]),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_be(dm_be), .o_dm_gnt(dm_gnt_w[1]), .o_dm_rvalid(dm_rvalid_w[1]),
    .o_dm_rdata(dm_rdata_w[1]), .o_ram_addr(ram_addr_w[1]), .o_ram_wdata(ram_wdata_w[1]),
    .o_ram_be(ram_be_w[1]), .o_ram_we(ram_we_w[1]), .o_ram_re(ram_re_w[1]),
    .i_ram_rdata(ram_rdata_w[1]));

  ram_port_arbiter #(.RAM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt_w[2]),
    .o_if_rvalid(if_rvalid_w[2]), .o_if_rdata(if_rdata_w[2]),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_be(dm_be), .o_dm_gnt(dm_gnt_w[2]), .o_dm_rvalid(dm_rvalid_w[2]),
    .o_dm_rdata(dm_rdata_w[2]), .o_ram_addr(ram_addr_w[2]), .o_ram_wdata(ram_wdata_w[2]),
    .o_ram_be(ram_be_w[2]), .o_ram_we(ram_we_w[2]), .o_ram_re(ram_re_w[2]),
    .i_ram_rdata(ram_rdata_w[2]));

  // Behavioural RAMs: write on the ram_we edge, sample on the ram_re edge,
  // present the word (k+1) cycles after ram_re; junk otherwise.
  logic [31:0] ram_mem   [3][256];
  logic [31:0] model_mem [256];
  logic [31:0] rpipe     [3][4];

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 'h10) return 32'hDEADBEEF;
    return {8'hA5, b, ~b, 8'h5A};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = init_word(i);
      for (int k = 0; k < 3; k++) ram_mem[k][i] = init_word(i);
    end
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 4; s++) rpipe[k][s] = 32'h0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ram_we_w[k])
        for (int b = 0; b < 4; b++)
          if (ram_be_w[k][b]) ram_mem[k][ram_addr_w[k][7:0]][b*8 +: 8] <= ram_wdata_w[k][b*8 +: 8];
      for (int s = 3; s > 0; s--) rpipe[k][s] <= rpipe[k][s-1];
      rpipe[k][0] <= ram_re_w[k] ? ram_mem[k][ram_addr_w[k][7:0]] : (32'hBAD00000 ^ 32'(cyc));
    end
  end

  assign ram_rdata_w[0] = rpipe[0][0];
  assign ram_rdata_w[1] = rpipe[1][1];
  assign ram_rdata_w[2] = rpipe[2][2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard model: arbitration rules, expected RAM port, pending reads
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int          due;
    logic        src;   // 1 = data port, 0 = fetch
    logic [31:0] data;
  } pend_t;

  pend_t       pq [3][$];
  pend_t       p;
  int          m_starve = 0;
  logic [29:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [3:0]  m_be     = '0;
  logic        m_we     = 1'b0;
  logic        m_re     = 1'b0;
  logic        e_if, e_dm, e_ifv, e_dmv;
  logic [31:0] e_dat;

  always @(negedge clk) begin
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rst) begin
      if (dm_req && if_req) begin
        if (m_starve == STARVE_MAX) e_if = 1'b1;
        else                        e_dm = 1'b1;
      end else begin
        e_dm = dm_req;
        e_if = if_req;
      end
    end

    for (int k = 0; k < 3; k++) begin
      check($sformatf("if_gnt[%0d]", k), 64'(if_gnt_w[k]), 64'(e_if));
      check($sformatf("dm_gnt[%0d]", k), 64'(dm_gnt_w[k]), 64'(e_dm));
      check($sformatf("ram_re[%0d]", k), 64'(ram_re_w[k]), 64'(m_re));
      check($sformatf("ram_we[%0d]", k), 64'(ram_we_w[k]), 64'(m_we));
      check($sformatf("ram_addr[%0d]", k), 64'(ram_addr_w[k]), 64'(m_addr));
      check($sformatf("ram_wdata[%0d]", k), 64'(ram_wdata_w[k]), 64'(m_wdata));
      check($sformatf("ram_be[%0d]", k), 64'(ram_be_w[k]), 64'(m_be));
      e_ifv = 1'b0;
      e_dmv = 1'b0;
      e_dat = '0;
      if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
        if (!rst) begin
          e_dmv = pq[k][0].src;
          e_ifv = ~pq[k][0].src;
          e_dat = pq[k][0].data;
        end
        void'(pq[k].pop_front());
      end
      check($sformatf("if_rvalid[%0d]", k), 64'(if_rvalid_w[k]), 64'(e_ifv));
      check($sformatf("dm_rvalid[%0d]", k), 64'(dm_rvalid_w[k]), 64'(e_dmv));
      if (e_ifv) check($sformatf("if_rdata[%0d]", k), 64'(if_rdata_w[k]), 64'(e_dat));
      if (e_dmv) check($sformatf("dm_rdata[%0d]", k), 64'(dm_rdata_w[k]), 64'(e_dat));
    end

    if (rst) begin
      for (int k = 0; k < 3; k++) pq[k].delete();
      m_starve = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0; m_re = 1'b0;
    end else begin
      if (e_dm && if_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
      else                m_starve = 0;
      m_we = 1'b0;
      m_re = 1'b0;
      if (e_dm && dm_we) begin
        m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be; m_we = 1'b1;
        for (int b = 0; b < 4; b++)
          if (dm_be[b]) model_mem[dm_addr[7:0]][b*8 +: 8] = dm_wdata[b*8 +: 8];
      end else if (e_dm || e_if) begin
        m_addr  = e_dm ? dm_addr : if_addr;
        m_wdata = '0;
        m_be    = 4'b1111;
        m_re    = 1'b1;
        for (int k = 0; k < 3; k++) begin
          p.due  = cyc + 2 + k;
          p.src  = e_dm;
          p.data = model_mem[m_addr[7:0]];
          pq[k].push_back(p);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic seq_dm [8];
  logic exp_seq [8];

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 30'h5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h6; dm_wdata = '0; dm_be = '0;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with both requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_gnt", 64'({if_gnt_w, dm_gnt_w}), 64'(0));
      check("rst_strobes", 64'({ram_re_w, ram_we_w}), 64'(0));
      check("rst_rvalid", 64'({if_rvalid_w, dm_rvalid_w}), 64'(0));
      tick();
    end
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (3) tick();

    // Single fetch
    if_req = 1'b1; if_addr = 30'h10;
    @(negedge clk); check("fetch_gnt", 64'(if_gnt_w[0]), 64'(1));
    tick(); if_req = 1'b0;
    @(negedge clk);
    check("fetch_ram_re", 64'(ram_re_w[0]), 64'(1));
    check("fetch_ram_addr", 64'(ram_addr_w[0]), 64'(30'h10));
    tick();
    @(negedge clk);
    check("fetch_rvalid", 64'(if_rvalid_w[0]), 64'(1));
    check("fetch_rdata", 64'(if_rdata_w[0]), 64'(32'hDEADBEEF));
    tick();
    @(negedge clk); check("fetch_rvalid_once", 64'(if_rvalid_w[0]), 64'(0));
    repeat (4) tick();

    // Store, then load of the same word in the next cycle
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 30'h20; dm_be = 4'b0100; dm_wdata = 32'h00AB0000;
    @(negedge clk); check("store_gnt", 64'(dm_gnt_w[0]), 64'(1));
    tick(); dm_we = 1'b0; dm_be = 4'b0000; dm_wdata = '0;
    @(negedge clk);
    check("store_ram_we", 64'(ram_we_w[0]), 64'(1));
    check("store_ram_re", 64'(ram_re_w[0]), 64'(0));
    check("store_ram_addr", 64'(ram_addr_w[0]), 64'(30'h20));
    check("store_ram_be", 64'(ram_be_w[0]), 64'(4'b0100));
    check("store_ram_wdata", 64'(ram_wdata_w[0]), 64'(32'h00AB0000));
    check("load_gnt", 64'(dm_gnt_w[0]), 64'(1));
    tick(); dm_req = 1'b0;
    @(negedge clk);
    check("load_ram_be", 64'(ram_be_w[0]), 64'(4'b1111));
    check("load_ram_wdata", 64'(ram_wdata_w[0]), 64'(0));
    tick();
    @(negedge clk);
    check("load_after_store_rvalid", 64'(dm_rvalid_w[0]), 64'(1));
    check("load_after_store_rdata", 64'(dm_rdata_w[0]), 64'(32'hA5ABDF5A));
    repeat (5) tick();

    // Contention: both requesting continuously
    if_req = 1'b1; if_addr = 30'h50; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 30'h40;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seq_dm[i] = dm_gnt_w[0];
      tick();
      if (seq_dm[i]) dm_addr = dm_addr + 30'd1;
      else           if_addr = if_addr + 30'd1;
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 8; i++)
      check($sformatf("contention_order[%0d]", i), 64'(seq_dm[i]), 64'(exp_seq[i]));
    repeat (6) tick();

    // Pipelined mixed reads, checked on the latency-2 instance
    dm_req = 1'b1; dm_addr = 30'h60; tick();
    dm_req = 1'b0; if_req = 1'b1; if_addr = 30'h61; tick();
    if_req = 1'b0; dm_req = 1'b1; dm_addr = 30'h62; tick();
    dm_req = 1'b0;
    @(negedge clk);
    check("pipe_c3_dm_rvalid", 64'(dm_rvalid_w[1]), 64'(1));
    check("pipe_c3_dm_rdata", 64'(dm_rdata_w[1]), 64'(32'hA5609F5A));
    tick();
    @(negedge clk);
    check("pipe_c4_if_rvalid", 64'(if_rvalid_w[1]), 64'(1));
    check("pipe_c4_dm_quiet", 64'(dm_rvalid_w[1]), 64'(0));
    check("pipe_c4_if_rdata", 64'(if_rdata_w[1]), 64'(32'hA5619E5A));
    tick();
    @(negedge clk);
    check("pipe_c5_dm_rvalid", 64'(dm_rvalid_w[1]), 64'(1));
    check("pipe_c5_dm_rdata", 64'(dm_rdata_w[1]), 64'(32'hA5629D5A));
    repeat (6) tick();

    // Reset while a fetch read is in flight
    if_req = 1'b1; if_addr = 30'h70;
    @(negedge clk); check("flight_gnt", 64'(if_gnt_w[2]), 64'(1));
    tick(); if_req = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk); check("flight_rst_rvalid", 64'(if_rvalid_w), 64'(0));
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("flight_dropped[%0d]", i), 64'(if_rvalid_w), 64'(0));
      tick();
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
